pll_reset_sequencer: RTL and testbench

Controls the reset and lock bring-up of the 50 MHz to 250 MHz PLL, and runs entirely in the free-running 50 MHz reference domain. It sits directly upstream of the PLL:
- drives the PLL `rst` pin;
- synchronizes the PLL `locked` pin;
- re-pulses the PLL reset on lock timeout or lock loss;
- releases a clean system reset only after lock has been stable for a programmable time.

Downstream blocks, including the 250 MHz FFT/atan2 datapath reset bridges, gate on `sys_rst_n` and `ready`.

---
 rtl/pll_ctrl_pkg.sv | 14 +
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_reset_sequencer.sv | 113 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL bring-up control blocks.
package pll_ctrl_pkg;

   typedef enum logic [1:0] {
      ASSERT    = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } pll_seq_state_t;

   localparam int RETRY_W = 8;
   localparam logic [RETRY_W-1:0] RETRY_MAX = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer; both flops clear to 0 on synchronous reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock bring-up sequencer in the reference clock domain.
// Outputs are registered and decoded from the next state, so they move with the state register.
module pll_reset_sequencer
   import pll_ctrl_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int STABLE_CYCLES       = 1024,
   parameter int CNT_W               = 17
) (
   input  logic               refclk,
   input  logic               rst_n,
   input  logic               locked,
   output logic               pll_rst,
   output logic               sys_rst_n,
   output logic               ready,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [1:0]         state_dbg
);

   localparam longint CNT_MAX = (longint'(1) << CNT_W) - longint'(1);

   generate
      if (RST_PULSE_CYCLES < 1 || longint'(RST_PULSE_CYCLES) > CNT_MAX ||
          LOCK_TIMEOUT_CYCLES < 1 || longint'(LOCK_TIMEOUT_CYCLES) > CNT_MAX ||
          STABLE_CYCLES < 1 || longint'(STABLE_CYCLES) > CNT_MAX) begin : g_bad_params
         $error("pll_reset_sequencer: cycle parameters must be in 1 .. 2**CNT_W-1");
      end
   endgenerate

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

   pll_seq_state_t   state;
   pll_seq_state_t   state_next;
   logic [CNT_W-1:0] cnt;
   logic             locked_s;
   logic             retry_inc;
   logic             pll_rst_d;
   logic             sys_rst_n_d;
   logic             ready_d;

   sync_2ff u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (locked),
      .q     (locked_s)
   );

   // State, shared counter (cleared on every state change), retry counter and outputs.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state     <= ASSERT;
         cnt       <= '0;
         retry_cnt <= '0;
         pll_rst   <= 1'b1;
         sys_rst_n <= 1'b0;
         ready     <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= (state_next != state) ? '0 : cnt + CNT_W'(1);
         if (retry_inc && retry_cnt != RETRY_MAX) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
         end
         pll_rst   <= pll_rst_d;
         sys_rst_n <= sys_rst_n_d;
         ready     <= ready_d;
      end
   end

   // A lock seen on the timeout cycle wins over the retry.
   always_comb begin
      state_next = state;
      retry_inc  = 1'b0;
      case (state)
         ASSERT: begin
            if (cnt == RST_LAST) state_next = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_next = STABLE;
            end else if (cnt == TIMEOUT_LAST) begin
               state_next = ASSERT;
               retry_inc  = 1'b1;
            end
         end
         STABLE: begin
            if (!locked_s) begin
               state_next = WAIT_LOCK;
            end else if (cnt == STABLE_LAST) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_next = ASSERT;
               retry_inc  = 1'b1;
            end
         end
         default: state_next = ASSERT;
      endcase
   end

   always_comb begin
      pll_rst_d   = (state_next == ASSERT);
      sys_rst_n_d = (state_next == RUN);
      ready_d     = (state_next == RUN);
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with short cycle parameters (4/20/8).
module tb_pll_reset_sequencer;
   import pll_ctrl_pkg::*;

   localparam int W = 13;

   logic       refclk = 1'b0;
   logic       rst_n  = 1'b0;
   logic       locked = 1'b0;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       ready;
   logic [7:0] retry_cnt;
   logic [1:0] state_dbg;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   pll_reset_sequencer #(
      .RST_PULSE_CYCLES    (4),
      .LOCK_TIMEOUT_CYCLES (20),
      .STABLE_CYCLES       (8),
      .CNT_W               (17)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .locked    (locked),
      .pll_rst   (pll_rst),
      .sys_rst_n (sys_rst_n),
      .ready     (ready),
      .retry_cnt (retry_cnt),
      .state_dbg (state_dbg)
   );

   // Clock / watchdog
   always #10 refclk = ~refclk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   // Expected observation: {state, pll_rst, sys_rst_n, ready, retry_cnt}
   function automatic logic [W-1:0] pk(input pll_seq_state_t s, input int r);
      logic [7:0] rr;
      rr = 8'(r);
      return {2'(s), s == ASSERT, s == RUN, s == RUN, rr};
   endfunction

   function automatic logic [W-1:0] observed();
      return {state_dbg, pll_rst, sys_rst_n, ready, retry_cnt};
   endfunction

   // Attempt cycle with no lock: 4 cycles ASSERT then 20 cycles WAIT_LOCK.
   function automatic pll_seq_state_t no_lock_state(input int e);
      return ((e % 24) < 4) ? ASSERT : WAIT_LOCK;
   endfunction

   // Driver: set inputs for edge e, queue the expectation for that edge, advance past it.
   task automatic drive_edge(input logic lk, input logic rn, input logic [W-1:0] exp);
      locked = lk;
      rst_n  = rn;
      exp_q.push_back(exp);
      @(posedge refclk);
      #1;
   endtask

   // Edge 0 is the last edge with rst_n low; counting restarts there.
   task automatic do_reset();
      exp_q.delete();
      locked = 1'b0;
      rst_n  = 1'b0;
      repeat (2) @(posedge refclk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [W-1:0] got;
      logic [W-1:0] exp;
      do_reset();
      got = observed();
      exp = pk(ASSERT, 0);
      n_checks++;
      if (got !== exp) $display("FAIL reset_state: got %h expected %h", got, exp);
      else n_pass++;
   endtask

   task automatic test_never_locks();
      logic [W-1:0] got;
      logic [W-1:0] exp;
      do_reset();
      for (int e = 1; e <= 52; e++) begin
         drive_edge(1'b0, 1'b1, pk(no_lock_state(e), e / 24));
         got = observed();
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) $display("FAIL never_locks edge %0d: got %h expected %h", e, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_normal_bringup();
      logic [W-1:0] got;
      logic [W-1:0] exp;
      pll_seq_state_t s;
      do_reset();
      for (int e = 1; e <= 24; e++) begin
         s = (e < 4) ? ASSERT : (e < 12) ? WAIT_LOCK : (e < 20) ? STABLE : RUN;
         drive_edge(e >= 10, 1'b1, pk(s, 0));
         got = observed();
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) $display("FAIL normal_bringup edge %0d: got %h expected %h", e, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_glitch_stable();
      logic [W-1:0] got;
      logic [W-1:0] exp;
      pll_seq_state_t s;
      do_reset();
      for (int e = 1; e <= 30; e++) begin
         s = (e < 4) ? ASSERT : (e < 12) ? WAIT_LOCK : (e < 17) ? STABLE :
             (e == 17) ? WAIT_LOCK : (e < 26) ? STABLE : RUN;
         drive_edge(e >= 10 && e != 15, 1'b1, pk(s, 0));
         got = observed();
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) $display("FAIL glitch_stable edge %0d: got %h expected %h", e, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_timeout_tie();
      logic [W-1:0] got;
      logic [W-1:0] exp;
      pll_seq_state_t s;
      do_reset();
      for (int e = 1; e <= 34; e++) begin
         s = (e < 4) ? ASSERT : (e < 24) ? WAIT_LOCK : (e < 32) ? STABLE : RUN;
         drive_edge(e >= 22, 1'b1, pk(s, 0));
         got = observed();
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) $display("FAIL timeout_tie edge %0d: got %h expected %h", e, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_lock_loss();
      logic [W-1:0] got;
      logic [W-1:0] exp;
      pll_seq_state_t s;
      do_reset();
      for (int e = 1; e <= 46; e++) begin
         s = (e < 4) ? ASSERT : (e < 12) ? WAIT_LOCK : (e < 20) ? STABLE : (e < 27) ? RUN :
             (e < 31) ? ASSERT : (e < 35) ? WAIT_LOCK : (e < 43) ? STABLE : RUN;
         drive_edge((e >= 10 && e < 25) || e >= 33, 1'b1, pk(s, (e >= 27) ? 1 : 0));
         got = observed();
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) $display("FAIL lock_loss edge %0d: got %h expected %h", e, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_saturation_reset();
      logic [W-1:0] got;
      logic [W-1:0] exp;
      pll_seq_state_t s;
      int r;
      do_reset();
      for (int e = 1; e <= 7200; e++) begin
         r = (e / 24 > 255) ? 255 : e / 24;
         drive_edge(1'b0, 1'b1, pk(no_lock_state(e), r));
         got = observed();
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) $display("FAIL saturation edge %0d: got %h expected %h", e, got, exp);
         else n_pass++;
      end
      // Re-lock into RUN while saturated, then a one-edge reset in RUN.
      for (int e = 7201; e <= 7221; e++) begin
         if (e == 7220) begin
            drive_edge(1'b1, 1'b0, pk(ASSERT, 0));
         end else if (e == 7221) begin
            drive_edge(1'b1, 1'b1, pk(ASSERT, 0));
         end else begin
            s = (e < 7204) ? ASSERT : (e < 7208) ? WAIT_LOCK : (e < 7216) ? STABLE : RUN;
            drive_edge(e >= 7206, 1'b1, pk(s, 255));
         end
         got = observed();
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) $display("FAIL run_reset edge %0d: got %h expected %h", e, got, exp);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_never_locks();
      test_normal_bringup();
      test_glitch_stable();
      test_timeout_tie();
      test_lock_loss();
      test_saturation_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
